// File: rtl/axi_read_arbiter.sv
// ----------------------------------------------------------------------------
// axi_read_arbiter
//   Merges the I-cache and D-cache AXI read channels (AR/R) onto a single AXI
//   master read port. One transaction is outstanding at a time: a client is
//   granted from IDLE, its AR request is forwarded, and the returned R beats
//   are steered back to it until the last beat, after which the FSM returns
//   to IDLE and arbitrates again.
//
//   State table:
//     state | meaning
//     IDLE  | nothing outstanding; arbitrating between i_arvalid / d_arvalid
//     I_AR  | I-cache granted, AR presented to memory, waiting for m_arready
//     I_R   | I-cache burst in flight, R beats steered to the I-cache
//     D_AR  | D-cache granted, AR presented to memory, waiting for m_arready
//     D_R   | D-cache burst in flight, R beats steered to the D-cache
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   i_ar*, i_r*              I-cache AR/R slave side (size fixed to 4 bytes)
//   d_ar*, d_r*, d_arsize    D-cache AR/R slave side
//   m_ar*, m_r*              AXI master read channel towards memory
//   proto_err                sticky: rlast at the wrong beat count, rid
//                            mismatch or non-OKAY rresp seen
//
// Configuration
//   ARB_ROUND_ROBIN_EN  defined: simultaneous requests in IDLE alternate,
//                       the client that lost the previous tie wins the next
//                       (D wins the first tie after reset).
//                       undefined: fixed priority, D always wins ties.
// ----------------------------------------------------------------------------
module axi_read_arbiter #(
    parameter int ID_WIDTH = 4,
    parameter int I_ID     = 0,
    parameter int D_ID     = 1
) (
    input  logic                clk,
    input  logic                rst,

    input  logic [31:0]         i_araddr,
    input  logic [7:0]          i_arlen,
    input  logic                i_arvalid,
    output logic                i_arready,
    output logic [31:0]         i_rdata,
    output logic                i_rlast,
    output logic                i_rvalid,
    input  logic                i_rready,

    input  logic [31:0]         d_araddr,
    input  logic [7:0]          d_arlen,
    input  logic [2:0]          d_arsize,
    input  logic                d_arvalid,
    output logic                d_arready,
    output logic [31:0]         d_rdata,
    output logic                d_rlast,
    output logic                d_rvalid,
    input  logic                d_rready,

    output logic [ID_WIDTH-1:0] m_arid,
    output logic [31:0]         m_araddr,
    output logic [7:0]          m_arlen,
    output logic [2:0]          m_arsize,
    output logic [1:0]          m_arburst,
    output logic                m_arvalid,
    input  logic                m_arready,
    input  logic [ID_WIDTH-1:0] m_rid,
    input  logic [31:0]         m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rlast,
    input  logic                m_rvalid,
    output logic                m_rready,

    output logic                proto_err
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        I_AR = 3'd1,
        I_R  = 3'd2,
        D_AR = 3'd3,
        D_R  = 3'd4
    } state_t;

    localparam logic [ID_WIDTH-1:0] I_ID_W = ID_WIDTH'(I_ID);
    localparam logic [ID_WIDTH-1:0] D_ID_W = ID_WIDTH'(D_ID);

    state_t              state_q, state_d;
    logic [7:0]          beat_cnt_q, beat_cnt_d;
    logic [7:0]          exp_len_q, exp_len_d;
    logic [ID_WIDTH-1:0] exp_id_q, exp_id_d;
    logic                proto_err_q, proto_err_d;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 when D won the most recent tie. Only contested grants update it, so a
    // lone request does not disturb the alternation between tied requests.
    logic                last_tie_d_q, last_tie_d_d;
`endif

    logic ar_hs;
    logic r_hs;

    assign ar_hs     = m_arvalid & m_arready;
    assign r_hs      = m_rvalid & m_rready;
    assign proto_err = proto_err_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_tie_d_d = last_tie_d_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_arvalid && d_arvalid) begin
`ifdef ARB_ROUND_ROBIN_EN
                    if (last_tie_d_q) begin
                        state_d = I_AR;
                    end else begin
                        state_d = D_AR;
                    end
                    last_tie_d_d = ~last_tie_d_q;
`else
                    state_d = D_AR;
`endif
                end else if (d_arvalid) begin
                    state_d = D_AR;
                end else if (i_arvalid) begin
                    state_d = I_AR;
                end
            end
            I_AR: if (ar_hs) state_d = I_R;
            D_AR: if (ar_hs) state_d = D_R;
            I_R:  if (r_hs && m_rlast) state_d = IDLE;
            D_R:  if (r_hs && m_rlast) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode: purely a function of the current state plus the
    // pass-through handshake signals of the granted client.
    // ------------------------------------------------------------------
    always_comb begin
        i_arready = 1'b0;
        i_rdata   = '0;
        i_rlast   = 1'b0;
        i_rvalid  = 1'b0;
        d_arready = 1'b0;
        d_rdata   = '0;
        d_rlast   = 1'b0;
        d_rvalid  = 1'b0;
        m_arid    = '0;
        m_araddr  = '0;
        m_arlen   = '0;
        m_arsize  = '0;
        m_arburst = 2'b01;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        case (state_q)
            I_AR: begin
                m_arid    = I_ID_W;
                m_araddr  = i_araddr;
                m_arlen   = i_arlen;
                m_arsize  = 3'b010;
                m_arvalid = i_arvalid;
                i_arready = m_arready;
            end
            D_AR: begin
                m_arid    = D_ID_W;
                m_araddr  = d_araddr;
                m_arlen   = d_arlen;
                m_arsize  = d_arsize;
                m_arvalid = d_arvalid;
                d_arready = m_arready;
            end
            I_R: begin
                i_rdata  = m_rdata;
                i_rlast  = m_rlast;
                i_rvalid = m_rvalid;
                m_rready = i_rready;
            end
            D_R: begin
                d_rdata  = m_rdata;
                d_rlast  = m_rlast;
                d_rvalid = m_rvalid;
                m_rready = d_rready;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Burst bookkeeping and protocol checking
    // beat_cnt_q holds the number of beats already accepted, so on the
    // rlast beat it must equal the issued arlen.
    // ------------------------------------------------------------------
    always_comb begin
        beat_cnt_d  = beat_cnt_q;
        exp_len_d   = exp_len_q;
        exp_id_d    = exp_id_q;
        proto_err_d = proto_err_q;
        if (ar_hs) begin
            beat_cnt_d = 8'd0;
            exp_len_d  = m_arlen;
            exp_id_d   = m_arid;
        end
        if (r_hs) begin
            beat_cnt_d = beat_cnt_q + 8'd1;
            if (m_rlast && (beat_cnt_q != exp_len_q)) proto_err_d = 1'b1;
            if (m_rid != exp_id_q)                    proto_err_d = 1'b1;
            if (m_rresp != 2'b00)                     proto_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            beat_cnt_q   <= 8'd0;
            exp_len_q    <= 8'd0;
            exp_id_q     <= '0;
            proto_err_q  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_tie_d_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            exp_len_q    <= exp_len_d;
            exp_id_q     <= exp_id_d;
            proto_err_q  <= proto_err_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_tie_d_q <= last_tie_d_d;
`endif
        end
    end

endmodule
